// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl - reset sequencing controller at the top of the reset tree.
//
// Turns power-on, software and watchdog reset events into per-domain,
// registered, active-low reset lines. All domains assert together, are held
// for ASSERT_CYCLES clocks, then release one at a time in ascending index
// order with GAP_CYCLES clocks between releases.
//
// Ports:
//   clk_i         system clock (only clock)
//   rst_i         asynchronous active-high power-on reset
//   sw_rst_req_i  software reset request, level-sampled every edge
//   wdt_expire_i  watchdog reset request, level-sampled every edge
//   dom_rst_n_o   per-domain active-low reset, straight from flops
//   busy_o        high while any domain is held or not yet released
//   rst_cause_o   cause of last sequence: 01 POR, 10 SW, 11 WDT
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HOLD    | all domains asserted, counting ASSERT_CYCLES
// ST_RELEASE | releasing domain idx after each GAP_CYCLES interval
// ST_IDLE    | all domains released, waiting for a request

module rst_seq_ctrl #(
  parameter int NUM_DOMAINS   = 2,
  parameter int ASSERT_CYCLES = 16,
  parameter int GAP_CYCLES    = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sw_rst_req_i,
  input  logic                   wdt_expire_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_n_o,
  output logic                   busy_o,
  output logic [1:0]             rst_cause_o
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_WIDTH-1:0] ASSERT_LAST = CNT_WIDTH'(ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
  logic                   busy_q, busy_d;
  logic [1:0]             cause_q, cause_d;

  logic req;
  assign req = sw_rst_req_i | wdt_expire_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dom_rst_n_d = dom_rst_n_q;
    busy_d      = busy_q;
    cause_d     = cause_q;

    if (req) begin
      // A request restarts the sequence from any state; watchdog wins a tie.
      state_d     = ST_HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      dom_rst_n_d = '0;
      busy_d      = 1'b1;
      cause_d     = wdt_expire_i ? CAUSE_WDT : CAUSE_SW;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == ASSERT_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            dom_rst_n_d[idx_q] = 1'b1;
            cnt_d              = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_IDLE;
              idx_d   = '0;
              busy_d  = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end

        ST_IDLE: begin
          dom_rst_n_d = '1;
          busy_d      = 1'b0;
        end

        default: begin
          // Unreachable encoding: recover by re-running the full sequence.
          state_d     = ST_HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          dom_rst_n_d = '0;
          busy_d      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_rst_n_q <= '0;
      busy_q      <= 1'b1;
      cause_q     <= CAUSE_POR;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_rst_n_q <= dom_rst_n_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
    end
  end

  assign dom_rst_n_o = dom_rst_n_q;
  assign busy_o      = busy_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;

  // Default configuration: A=16, G=4, N=2
  localparam int A1 = 16;
  localparam int G1 = 4;
  localparam int N1 = 2;
  localparam int SEQ1 = A1 + N1 * G1;  // 24

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sw  = 1'b0;
  logic          wdt = 1'b0;
  logic [1:0]    dom1;
  logic          busy1;
  logic [1:0]    cause1;

  // Minimal configuration: N=3, A=1, G=1
  logic          sw2  = 1'b0;
  logic          wdt2 = 1'b0;
  logic [2:0]    dom2;
  logic          busy2;
  logic [1:0]    cause2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .sw_rst_req_i (sw),
    .wdt_expire_i (wdt),
    .dom_rst_n_o  (dom1),
    .busy_o       (busy1),
    .rst_cause_o  (cause1)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS   (3),
    .ASSERT_CYCLES (1),
    .GAP_CYCLES    (1),
    .CNT_WIDTH     (4)
  ) dut2 (
    .clk_i        (clk),
    .rst_i        (rst),
    .sw_rst_req_i (sw2),
    .wdt_expire_i (wdt2),
    .dom_rst_n_o  (dom2),
    .busy_o       (busy2),
    .rst_cause_o  (cause2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected default-config domain vector e edges into a sequence.
  function automatic logic [1:0] exp_dom1(input int e);
    logic [1:0] v;
    v = '0;
    for (int k = 0; k < N1; k++)
      if (e >= A1 + (k + 1) * G1) v[k] = 1'b1;
    return v;
  endfunction

  // Hand-computed dom2 pattern: 000, 001 at edge 2, 011 at 3, 111 at 4.
  function automatic logic [2:0] exp_dom2(input int e);
    if (e >= 4) return 3'b111;
    if (e == 3) return 3'b011;
    if (e == 2) return 3'b001;
    return 3'b000;
  endfunction

  // Walk the default-config sequence for SEQ1 edges after its start point.
  task automatic seq1_walk(input string tag, input logic [1:0] cause);
    for (int e = 1; e <= SEQ1; e++) begin
      tick();
      chk($sformatf("%s dom e%0d", tag, e), 32'(dom1), 32'(exp_dom1(e)));
      chk($sformatf("%s busy e%0d", tag, e), 32'(busy1), (e < SEQ1) ? 32'd1 : 32'd0);
    end
    chk({tag, " cause"}, 32'(cause1), 32'(cause));
    tick();
    chk({tag, " idle dom"}, 32'(dom1), 32'h3);
    chk({tag, " idle busy"}, 32'(busy1), 32'd0);
  endtask

  // POR sequence from deassertion: rst drops between edges.
  task automatic por_walk(input string tag);
    chk({tag, " rst dom1"}, 32'(dom1), 32'd0);
    chk({tag, " rst busy1"}, 32'(busy1), 32'd1);
    chk({tag, " rst cause1"}, 32'(cause1), 32'h1);
    chk({tag, " rst dom2"}, 32'(dom2), 32'd0);
    chk({tag, " rst busy2"}, 32'(busy2), 32'd1);
    rst = 1'b0;
    for (int e = 1; e <= SEQ1; e++) begin
      tick();
      chk($sformatf("%s dom e%0d", tag, e), 32'(dom1), 32'(exp_dom1(e)));
      chk($sformatf("%s busy e%0d", tag, e), 32'(busy1), (e < SEQ1) ? 32'd1 : 32'd0);
      if (e <= 5) begin
        chk($sformatf("%s dom2 e%0d", tag, e), 32'(dom2), 32'(exp_dom2(e)));
        chk($sformatf("%s busy2 e%0d", tag, e), 32'(busy2), (e < 4) ? 32'd1 : 32'd0);
      end
    end
    chk({tag, " cause1"}, 32'(cause1), 32'h1);
    chk({tag, " cause2"}, 32'(cause2), 32'h1);
  endtask

  // Request held for hold_edges edges; sequence counted from the last one.
  task automatic req_seq(input string tag, input logic s, input logic w,
                         input int hold_edges, input logic [1:0] cause);
    sw  = s;
    wdt = w;
    for (int h = 0; h < hold_edges; h++) begin
      tick();
      chk($sformatf("%s req dom h%0d", tag, h), 32'(dom1), 32'd0);
      chk($sformatf("%s req busy h%0d", tag, h), 32'(busy1), 32'd1);
      chk($sformatf("%s req cause h%0d", tag, h), 32'(cause1), 32'(cause));
    end
    sw  = 1'b0;
    wdt = 1'b0;
    seq1_walk(tag, cause);
  endtask

  initial begin
    // Power-on with both configurations
    tick();
    tick();
    por_walk("por");

    // Idle holds steady, cause readable
    tick();
    tick();
    chk("idle dom", 32'(dom1), 32'h3);
    chk("idle busy", 32'(busy1), 32'd0);
    chk("idle cause", 32'(cause1), 32'h1);

    // Single-cycle SW pulse
    req_seq("sw", 1'b1, 1'b0, 1, 2'b10);

    // SW and WDT together: WDT wins, same timing
    req_seq("both", 1'b1, 1'b1, 1, 2'b11);

    // Level request held three edges restarts HOLD each edge
    req_seq("held", 1'b1, 1'b0, 3, 2'b10);

    // Restart during RELEASE: WDT one edge after domain 0 releases
    sw = 1'b1;
    tick();
    sw = 1'b0;
    for (int e = 1; e <= A1 + G1; e++) tick();
    chk("rel dom0 released", 32'(dom1), 32'h1);
    chk("rel busy", 32'(busy1), 32'd1);
    chk("rel cause sw", 32'(cause1), 32'h2);
    req_seq("restart", 1'b0, 1'b1, 1, 2'b11);

    // Async RST mid-HOLD after an SW request
    sw = 1'b1;
    tick();
    sw = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    chk("mid cause sw", 32'(cause1), 32'h2);
    sw2 = 1'b1;
    tick();
    sw2 = 1'b0;
    chk("mid dom2 asserted", 32'(dom2), 32'd0);
    chk("mid cause2 sw", 32'(cause2), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("async cause", 32'(cause1), 32'h1);
    chk("async dom", 32'(dom1), 32'd0);
    chk("async busy", 32'(busy1), 32'd1);
    chk("async cause2", 32'(cause2), 32'h1);
    tick();
    por_walk("por2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencing controller at the top of the reset tree: turns power-on, software and watchdog reset events into per-domain, registered, active-low reset lines that feed each clock domain's reset synchronizer. All domains assert together, are held for a programmable minimum time, then release one at a time in index order with a fixed gap. The block also reports busy status and the cause of the last reset.

## Interface
- NUM_DOMAINS, 2: number of domain reset outputs (≥1)
- ASSERT_CYCLES, 16: CLK cycles all domains are held in reset (≥1)
- GAP_CYCLES, 4: CLK cycles between successive domain releases (≥1)
- CNT_WIDTH, 8: counter width; ASSERT_CYCLES and GAP_CYCLES must be ≤ 2^CNT_WIDTH
- CLK  input  1  system clock, the only clock
- RST  input  1  asynchronous, active-high reset (power-on)
- SW_RST_REQ  input  1  software reset request, synchronous to CLK, sampled each edge
- WDT_EXPIRE  input  1  watchdog reset request, synchronous to CLK, sampled each edge
- DOM_RST_N  output  NUM_DOMAINS  registered active-low reset per domain; bit k drives domain k
- BUSY  output  1  high while any domain is held in reset or not yet released
- RST_CAUSE  output  2  cause of most recent sequence: 01 POR, 10 SW, 11 WDT (00 never driven)

## Operation
- State machine: HOLD, RELEASE, IDLE. Internal cnt (CNT_WIDTH) and idx (domain index).
- RST high (async): state=HOLD, cnt=0, idx=0, DOM_RST_N=all 0, BUSY=1, RST_CAUSE=01.
- HOLD: cnt increments each edge. At the edge where cnt==ASSERT_CYCLES-1: go to RELEASE, cnt=0, idx=0.
- RELEASE: cnt increments each edge. At the edge where cnt==GAP_CYCLES-1: DOM_RST_N[idx]=1, cnt=0, idx=idx+1. If idx was NUM_DOMAINS-1: go to IDLE and BUSY=0 on the same edge.
- IDLE: DOM_RST_N=all 1, BUSY=0. Any request sampled high: go to HOLD, DOM_RST_N=all 0, BUSY=1, cnt=0, idx=0, RST_CAUSE updated.
- Request in HOLD or RELEASE restarts the sequence:
  - go to HOLD with cnt=0, all domains re-asserted, RST_CAUSE updated.
  - Already-released domains go low again.
- Simultaneous SW_RST_REQ and WDT_EXPIRE: WDT has priority, RST_CAUSE=11.
- RST_CAUSE holds its value until the next request or RST. It is readable while IDLE.
- Release order is strictly ascending index. Domain k never releases before domain k-1.
- DOM_RST_N come straight from flops, with no combinational logic after the register.
- Requests are level-sampled. A request held high for several cycles restarts HOLD on every edge, so reset is held until the request drops plus the full sequence.

## Timing
- Edges are counted after RST deasserts; edge 1 is the first rising CLK edge.
- Edge ASSERT_CYCLES: HOLD→RELEASE.
- Domain k releases at edge ASSERT_CYCLES + (k+1)·GAP_CYCLES.
- Defaults: domain 0 releases at edge 20, domain 1 at edge 24. BUSY falls at edge 24.
- Request latency: a request sampled at edge E drives all DOM_RST_N low and BUSY high after edge E (1 cycle). The sequence then completes ASSERT_CYCLES + NUM_DOMAINS·GAP_CYCLES edges after E.
- RST asserted mid-sequence: outputs go to their reset values immediately, with no clock needed. Cause becomes 01.
- RST deassertion is synchronised externally. This block does not resynchronise RST.

## Test plan
- POR with defaults: release RST, hold requests low.
  - DOM_RST_N=00 through edge 19, 01 at edge 20, 11 at edge 24.
  - BUSY falls at edge 24. RST_CAUSE=01.
- SW request from IDLE: 1-cycle SW_RST_REQ pulse at edge E.
  - DOM_RST_N=00 after E, 01 at E+20, 11 at E+24. RST_CAUSE=10.
- Simultaneous SW and WDT pulse in IDLE: RST_CAUSE=11, sequence timing identical to the SW case.
- Restart during RELEASE: WDT pulse one edge after domain 0 releases.
  - DOM_RST_N returns to 00 and the full 24-edge sequence restarts. RST_CAUSE=11.
- Async RST mid-HOLD (after an SW request): assert RST between clock edges.
  - RST_CAUSE=01 and outputs at reset values before the next edge.
  - Full POR sequence follows deassertion.
- NUM_DOMAINS=3, ASSERT_CYCLES=1, GAP_CYCLES=1:
  - Domains release at edges 2, 3, 4 in order 001, 011, 111.
  - BUSY falls at edge 4.
